// File: rtl/rgmii_frame_sender.sv
// RGMII 100 Mb/s test-frame generator.
// Emits broadcast frames with a counting payload and CRC-32 FCS.
module rgmii_frame_sender #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          PAYLOAD_LEN = 46,
  parameter int          IFG_BYTES   = 12
) (
  input  logic       ETH_RXCLK,
  input  logic       RSTN,
  output logic [3:0] ETH_TX,
  output logic       ETH_TXCLK,
  output logic       ETH_TXCTRL
);

  typedef enum logic [2:0] {
    GAP, PRE, SFD, HDR, PAY, FCS
  } state_t;

  localparam logic [111:0] HDR_BITS =
    {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [15:0] GAP_LAST = 16'(IFG_BYTES - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);

  state_t      state;
  logic [2:0]  div;
  logic        hi;
  logic [15:0] cnt;
  logic [7:0]  seq;
  logic [31:0] crc;
  logic [31:0] crc_fin;
  logic [7:0]  cur;
  logic        last;
  logic        wrap;
  logic [6:0]  hidx;
  logic [4:0]  fidx;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign wrap    = (div == 3'd4);
  assign crc_fin = ~crc;
  assign hidx    = 7'd104 - {cnt[3:0], 3'b000};
  assign fidx    = {cnt[1:0], 3'b000};

  always_comb begin
    cur  = 8'h00;
    last = 1'b0;
    unique case (state)
      GAP: last = (cnt == GAP_LAST);
      PRE: begin
        cur  = 8'h55;
        last = (cnt == 16'd6);
      end
      SFD: begin
        cur  = 8'hD5;
        last = 1'b1;
      end
      HDR: begin
        cur  = HDR_BITS[hidx +: 8];
        last = (cnt == 16'd13);
      end
      PAY: begin
        cur  = seq + cnt[7:0];
        last = (cnt == PAY_LAST);
      end
      FCS: begin
        cur  = crc_fin[fidx +: 8];
        last = (cnt == 16'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ETH_RXCLK or negedge RSTN) begin
    if (!RSTN) begin
      div        <= '0;
      ETH_TXCLK  <= 1'b0;
      ETH_TX     <= '0;
      ETH_TXCTRL <= 1'b0;
      state      <= GAP;
      cnt        <= '0;
      // idle nibble 0 is the one on the wire during reset
      hi         <= 1'b1;
      seq        <= '0;
      crc        <= '1;
    end else begin
      div       <= wrap ? 3'd0 : div + 3'd1;
      ETH_TXCLK <= (div == 3'd2) || (div == 3'd3);
      if (wrap) begin
        ETH_TX     <= hi ? cur[7:4] : cur[3:0];
        ETH_TXCTRL <= (state != GAP);
        hi         <= ~hi;
        if (hi) begin
          if (state == HDR || state == PAY)
            crc <= crc8(crc, cur);
          cnt <= last ? 16'd0 : cnt + 16'd1;
          if (last) begin
            unique case (state)
              GAP: state <= PRE;
              PRE: state <= SFD;
              SFD: begin
                state <= HDR;
                crc   <= '1;
              end
              HDR: state <= PAY;
              PAY: state <= FCS;
              FCS: begin
                state <= GAP;
                seq   <= seq + 8'd1;
              end
              default: state <= GAP;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgmii_frame_sender.sv
// Scoreboard bench for rgmii_frame_sender.
// Expected nibbles come from a bench-side frame model.
module tb_rgmii_frame_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] tx;
  logic       txclk;
  logic       txctrl;

  rgmii_frame_sender dut (
    .ETH_RXCLK (clk),
    .RSTN      (rst_n),
    .ETH_TX    (tx),
    .ETH_TXCLK (txclk),
    .ETH_TXCTRL(txctrl)
  );

  always #4 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  logic [3:0] exp_q[$];

  task automatic push_frame(input logic [7:0] s);
    logic [7:0]  fr[$];
    logic [7:0]  h[14];
    logic [31:0] c;
    logic [31:0] f;
    h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
          8'h88, 8'hB5};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      fr.push_back(h[i]);
      c = crc_step(c, h[i]);
    end
    for (int k = 0; k < 46; k++) begin
      fr.push_back(s + 8'(k));
      c = crc_step(c, s + 8'(k));
    end
    f = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
    foreach (fr[i]) begin
      exp_q.push_back(fr[i][3:0]);
      exp_q.push_back(fr[i][7:4]);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       prev_txclk = 1'b0;
  bit         in_frame = 1'b0;
  int         frame_nib = 0;
  int         gap_nib = 0;
  int         frames_done = 0;
  int         last_start = -1;
  int         seq_model = 0;
  logic [3:0] lo_nib;
  logic [7:0] fbytes[$];
  logic [7:0] last_pay0;
  logic [31:0] res;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 1'b0;
      frame_nib  = 0;
      gap_nib    = 0;
      last_start = -1;
      seq_model  = 0;
      exp_q.delete();
      fbytes.delete();
    end else if (txclk && !prev_txclk) begin
      if (txctrl) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          frame_nib = 0;
          fbytes.delete();
          chk("gap_nibs", gap_nib, 24);
          if (last_start >= 0)
            chk("frame_period", cyc - last_start, 840);
          last_start = cyc;
          push_frame(8'(seq_model));
          seq_model++;
        end
        if (exp_q.size() == 0)
          chk("nib_underrun", 32'd1, 32'd0);
        else
          chk("nib", {28'h0, tx}, {28'h0, exp_q.pop_front()});
        if (frame_nib[0] == 1'b0)
          lo_nib = tx;
        else
          fbytes.push_back({tx, lo_nib});
        frame_nib++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          chk("frame_nibs", frame_nib, 144);
          if (fbytes.size() == 72) begin
            last_pay0 = fbytes[22];
            chk("pay0", {24'h0, last_pay0},
                32'(8'(seq_model - 1)));
            res = 32'hFFFF_FFFF;
            for (int i = 8; i < 72; i++)
              res = crc_step(res, fbytes[i]);
            chk("residue", res, 32'hDEBB_20E3);
          end
          frames_done++;
          gap_nib = 0;
        end
        chk("gap_tx", {28'h0, tx}, 32'd0);
        gap_nib++;
      end
    end
    prev_txclk = txclk;
  end

  task automatic wait_rise(input string tag, input int rel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = txctrl;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk(tag, cyc - rel, 120);
  endtask

  int rel;
  int fd0;
  bit ok;

  initial begin
    #1 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_out", {26'h0, tx, txclk, txctrl}, 32'd0);
    end
    rst_n = 1'b1;
    rel = cyc;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("txclk_pat", 32'(txclk),
          32'(((cyc - rel) % 5) >= 3));
    end
    wait_rise("first_rise", rel);

    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (frames_done == 3) && in_frame && (frame_nib >= 60);
    end
    chk("reach_frame3", 32'(ok), 32'd1);

    #1 rst_n = 1'b0;
    #1 chk("async_rst", {26'h0, tx, txclk, txctrl}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    fd0 = frames_done;
    wait_rise("rerun_rise", rel);

    ok = 1'b0;
    for (int i = 0; i < 2500 && !ok; i++) begin
      @(negedge clk);
      ok = (frames_done >= fd0 + 1);
    end
    chk("rerun_frame", 32'(ok), 32'd1);
    if (ok) chk("pay0_after_rst", {24'h0, last_pay0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
